// File: rtl/icache_line_fill_pkg.sv
// ==== icache_line_fill_pkg: cache geometry, fill FSM states, address helpers ==== rev 1.0
`default_nettype none
package icache_line_fill_pkg;

    localparam int NUM_LINES      = 16;
    localparam int WORDS_PER_LINE = 8;
    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;

    localparam int WORD_OFF_W = $clog2(WORDS_PER_LINE);
    localparam int OFF_W      = WORD_OFF_W + 2;
    localparam int IDX_W      = $clog2(NUM_LINES);
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] get_idx(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: IDX_W];
    endfunction

    function automatic logic [WORD_OFF_W-1:0] get_word(input logic [ADDR_W-1:0] addr);
        return addr[2 +: WORD_OFF_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_line_fill_if.sv
// ==== icache_line_fill_if: fetch-side lookup and memory refill signals ==== rev 1.0
`default_nettype none
interface icache_line_fill_if;
    import icache_line_fill_pkg::*;

    logic [ADDR_W-1:0] pc;
    logic              update;
    logic              invalidate;
    logic              hit;
    logic              miss;
    logic [DATA_W-1:0] rd_data;
    logic              fill_busy;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    // slave is the cache; master is the fetch stage / memory environment
    modport slave (
        input  pc, update, invalidate, mem_rvalid, mem_rdata,
        output hit, miss, rd_data, fill_busy, mem_req, mem_addr
    );

    modport master (
        output pc, update, invalidate, mem_rvalid, mem_rdata,
        input  hit, miss, rd_data, fill_busy, mem_req, mem_addr
    );

endinterface
`default_nettype wire

// File: rtl/icache_data_array.sv
// ==== icache_data_array: line x word instruction storage, 1 sync write, 1 comb read ==== rev 1.0
`default_nettype none
module icache_data_array
    import icache_line_fill_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  we,
    input  wire logic [IDX_W-1:0]      wr_line,
    input  wire logic [WORD_OFF_W-1:0] wr_word,
    input  wire logic [DATA_W-1:0]     wr_data,
    input  wire logic [IDX_W-1:0]      rd_line,
    input  wire logic [WORD_OFF_W-1:0] rd_word,
    output logic      [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem [NUM_LINES][WORDS_PER_LINE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_line][wr_word] <= wr_data;
        end
    end

    assign rd_data = mem[rd_line][rd_word];

endmodule
`default_nettype wire

// File: rtl/icache_line_fill.sv
// ==== icache_line_fill: direct-mapped I-cache tags/valids plus word-by-word line refill ==== rev 1.0
`default_nettype none
module icache_line_fill
    import icache_line_fill_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    icache_line_fill_if.slave bus
);

    localparam logic [WORD_OFF_W-1:0] CNT_MAX = WORD_OFF_W'(WORDS_PER_LINE - 1);

    fill_state_t state;
    fill_state_t state_nxt;

    logic [WORD_OFF_W-1:0] cnt;
    logic [TAG_W-1:0]      base_tag;
    logic [IDX_W-1:0]      base_idx;
    logic [NUM_LINES-1:0]  valid;
    logic [TAG_W-1:0]      tag_ram [NUM_LINES];

    logic [TAG_W-1:0]      pc_tag;
    logic [IDX_W-1:0]      pc_idx;
    logic [WORD_OFF_W-1:0] pc_word;
    logic                  busy;
    logic                  line_match;
    logic                  miss_w;
    logic                  start;
    logic                  word_we;
    logic                  fill_last;
    logic                  commit;
    logic                  mem_req_w;

    assign pc_tag  = get_tag(bus.pc);
    assign pc_idx  = get_idx(bus.pc);
    assign pc_word = get_word(bus.pc);

    assign busy       = (state != IDLE);
    assign line_match = valid[pc_idx] && (tag_ram[pc_idx] == pc_tag);
    assign miss_w     = !line_match && !busy;

    // invalidate on the final beat wins: the line is neither tagged nor validated
    assign commit = fill_last && !bus.invalidate;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        word_we   = 1'b0;
        fill_last = 1'b0;
        mem_req_w = 1'b0;
        case (state)
            IDLE: begin
                if (bus.update && miss_w) begin
                    start     = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                mem_req_w = 1'b1;
                word_we   = bus.mem_rvalid;
                fill_last = bus.mem_rvalid && (cnt == CNT_MAX);
                if (bus.invalidate) begin
                    state_nxt = IDLE;
                end else if (fill_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            base_tag <= '0;
            base_idx <= '0;
            valid    <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                cnt      <= '0;
                base_tag <= pc_tag;
                base_idx <= pc_idx;
            end else if (word_we) begin
                cnt <= cnt + 1'b1;
            end
            if (bus.invalidate) begin
                valid <= '0;
            end else if (commit) begin
                valid[base_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            tag_ram[base_idx] <= base_tag;
        end
    end

    icache_data_array u_data (
        .clk     (clk),
        .we      (word_we),
        .wr_line (base_idx),
        .wr_word (cnt),
        .wr_data (bus.mem_rdata),
        .rd_line (pc_idx),
        .rd_word (pc_word),
        .rd_data (bus.rd_data)
    );

    assign bus.hit       = line_match && !busy;
    assign bus.miss      = miss_w;
    assign bus.fill_busy = busy;
    assign bus.mem_req   = mem_req_w;
    assign bus.mem_addr  = (state == FILL) ? {base_tag, base_idx, cnt, 2'b00} : '0;

endmodule
`default_nettype wire

// File: tb/tb_icache_line_fill.sv
// ==== tb_icache_line_fill: directed checks of lookup, refill, stall, invalidate and reset abort ==== rev 1.0
`default_nettype none
module tb_icache_line_fill;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    icache_line_fill_if bus ();

    icache_line_fill dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] a);
        bus.pc = a;
        #1;
    endtask

    // Full refill of the line at base; words are dbase+i, one idle cycle before each reply
    task automatic run_fill(input logic [31:0] base, input logic [31:0] dbase,
                            input int stall_word, input int stall_len, input bit inv_last);
        set_pc(base);
        check("start_miss", {31'd0, bus.miss}, 32'd1);
        bus.update = 1'b1;
        tick();
        bus.update = 1'b0;
        check("fill_busy", {31'd0, bus.fill_busy}, 32'd1);
        check("fill_no_hit", {30'd0, bus.hit, bus.miss}, 32'd0);
        for (int w = 0; w < 8; w++) begin
            check("req", {31'd0, bus.mem_req}, 32'd1);
            check("addr", bus.mem_addr, base + 32'(w * 4));
            tick();
            if (w == stall_word) begin
                for (int s = 0; s < stall_len; s++) begin
                    check("stall_req", {31'd0, bus.mem_req}, 32'd1);
                    check("stall_addr", bus.mem_addr, base + 32'(w * 4));
                    tick();
                end
            end
            check("addr_hold", bus.mem_addr, base + 32'(w * 4));
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = dbase + 32'(w);
            if (w == 7 && inv_last) bus.invalidate = 1'b1;
            tick();
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'h0;
            bus.invalidate = 1'b0;
        end
        if (inv_last) begin
            #1;
            check("inv_busy", {31'd0, bus.fill_busy}, 32'd0);
            check("inv_req", {31'd0, bus.mem_req}, 32'd0);
            check("inv_miss", {31'd0, bus.miss}, 32'd1);
        end else begin
            check("done_busy", {31'd0, bus.fill_busy}, 32'd1);
            check("done_req", {31'd0, bus.mem_req}, 32'd0);
            check("done_hit", {31'd0, bus.hit}, 32'd0);
            tick();
            check("idle_busy", {31'd0, bus.fill_busy}, 32'd0);
            check("post_hit", {31'd0, bus.hit}, 32'd1);
            check("post_rd", bus.rd_data, dbase);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        bus.pc         = 32'h100;
        bus.update     = 1'b0;
        bus.invalidate = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;

        // 1: reset state
        #12;
        check("rst_hit", {31'd0, bus.hit}, 32'd0);
        check("rst_miss", {31'd0, bus.miss}, 32'd1);
        check("rst_busy", {31'd0, bus.fill_busy}, 32'd0);
        check("rst_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_addr", bus.mem_addr, 32'h0);
        rst_n = 1'b1;
        tick();

        // 2: first fill at 0x100
        run_fill(32'h100, 32'hA0, -1, 0, 1'b0);
        set_pc(32'h11C);
        check("t2_rd7", bus.rd_data, 32'hA7);
        check("t2_hit7", {31'd0, bus.hit}, 32'd1);

        // 3: same index, different tag
        set_pc(32'h300);
        check("t3_miss", {31'd0, bus.miss}, 32'd1);
        run_fill(32'h300, 32'hB0, -1, 0, 1'b0);
        set_pc(32'h100);
        check("t3_old_miss", {31'd0, bus.miss}, 32'd1);
        set_pc(32'h314);
        check("t3_rd5", bus.rd_data, 32'hB5);
        // update on a hit is ignored
        bus.update = 1'b1;
        tick();
        bus.update = 1'b0;
        check("t3_upd_hit", {31'd0, bus.fill_busy}, 32'd0);

        // 4: five-cycle memory stall mid-fill
        run_fill(32'h220, 32'hE0, 4, 5, 1'b0);
        set_pc(32'h230);
        check("t4_rd4", bus.rd_data, 32'hE4);
        set_pc(32'h23C);
        check("t4_rd7", bus.rd_data, 32'hE7);

        // 5: invalidate together with the final reply
        run_fill(32'h440, 32'hC0, -1, 0, 1'b1);
        set_pc(32'h300);
        check("t5_300_miss", {31'd0, bus.miss}, 32'd1);
        set_pc(32'h220);
        check("t5_220_miss", {31'd0, bus.miss}, 32'd1);
        set_pc(32'h440);
        check("t5_440_miss", {31'd0, bus.miss}, 32'd1);
        check("t5_rd0", bus.rd_data, 32'hC0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        check("t5_stray_rd0", bus.rd_data, 32'hC0);
        check("t5_stray_busy", {31'd0, bus.fill_busy}, 32'd0);

        // 6: reset during word 3 of a fill
        set_pc(32'h100);
        bus.update = 1'b1;
        tick();
        bus.update = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tick();
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'h70 + 32'(w);
            tick();
            bus.mem_rvalid = 1'b0;
        end
        check("t6_addr3", bus.mem_addr, 32'h10C);
        rst_n = 1'b0;
        #1;
        check("t6_rst_req", {31'd0, bus.mem_req}, 32'd0);
        check("t6_rst_busy", {31'd0, bus.fill_busy}, 32'd0);
        check("t6_rst_miss", {31'd0, bus.miss}, 32'd1);
        #2;
        rst_n = 1'b1;
        tick();
        check("t6_after_busy", {31'd0, bus.fill_busy}, 32'd0);
        check("t6_after_miss", {31'd0, bus.miss}, 32'd1);
        run_fill(32'h100, 32'hD0, -1, 0, 1'b0);
        set_pc(32'h11C);
        check("t6_rd7", bus.rd_data, 32'hD7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
